// File: rtl/pulse_sched_pkg.sv
// Shared types and default sizing for the pulse scheduling arbiter.
// Imported by the top and the round-robin selector.
package pulse_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int GAP_W_DEF   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_sched_arbiter_rr.sv
// Combinational round-robin selector: the search starts one past
// the last grant and wraps, returning a one-hot grant and its index.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IW'((int'(i_last) + k) % N);
      if (!w_found && i_pend[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

  assign o_any = |i_pend;

endmodule

// File: rtl/pulse_sched_arbiter.sv
// Queues single-cycle requests and issues them one pulse at a time,
// round-robin, with a configurable idle gap after every pulse.
module pulse_sched_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int GAP_W   = GAP_W_DEF
) (
  input  logic                       clk_fast,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_in,
  input  logic [GAP_W-1:0]           gap_cfg,
  input  logic                       clr_ovf,
  output logic                       pulse_out,
  output logic [$clog2(NUM_REQ)-1:0] pulse_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         ovf,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             r_state;
  logic [GAP_W-1:0]   r_cnt;
  logic [IW-1:0]      r_last;
  logic [IW-1:0]      r_id;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_ovf;
  logic               r_pulse;
  logic               r_busy;

  state_t             w_nxt;
  logic [GAP_W-1:0]   w_cnt_nxt;
  logic [IW-1:0]      w_last_nxt;
  logic [IW-1:0]      w_id_nxt;
  logic [NUM_REQ-1:0] w_take;
  logic               w_pulse_nxt;
  logic               w_busy_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_idx;
  logic               w_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .i_pend (r_pending),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_nxt       = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_id_nxt    = r_id;
    w_take      = '0;
    w_pulse_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable && w_any) begin
          w_nxt       = S_ISSUE;
          w_take      = w_gnt;
          w_id_nxt    = w_idx;
          w_last_nxt  = w_idx;
          w_cnt_nxt   = gap_cfg;
          w_pulse_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_cnt == '0) begin
          w_nxt = S_IDLE;
        end else begin
          w_nxt      = S_GAP;
          w_busy_nxt = 1'b1;
        end
      end
      S_GAP: begin
        w_cnt_nxt = r_cnt - GAP_W'(1);
        if (r_cnt == GAP_W'(1)) begin
          w_nxt = S_IDLE;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // A request landing on its own grant edge re-queues without overflow.
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_id      <= '0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_id      <= w_id_nxt;
      r_pending <= (r_pending & ~w_take) | req_in;
      r_ovf     <= (clr_ovf ? '0 : r_ovf)
                 | (req_in & r_pending & ~w_take);
      r_pulse   <= w_pulse_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign pulse_out = r_pulse;
  assign pulse_id  = r_id;
  assign pending   = r_pending;
  assign ovf       = r_ovf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pulse_sched_arbiter.sv
// Directed scenarios; expected pulses go to a queue that a
// negedge monitor pops and checks for id and cycle.
module tb_pulse_sched_arbiter;

  logic       clk_fast = 1'b0;
  logic       rst_n    = 1'b0;
  logic       enable   = 1'b1;
  logic [3:0] req_in   = '0;
  logic [7:0] gap_cfg  = '0;
  logic       clr_ovf  = 1'b0;
  logic       pulse_out;
  logic [1:0] pulse_id;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic       busy;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pulse_sched_arbiter dut (
    .clk_fast  (clk_fast),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_in    (req_in),
    .gap_cfg   (gap_cfg),
    .clr_ovf   (clr_ovf),
    .pulse_out (pulse_out),
    .pulse_id  (pulse_id),
    .pending   (pending),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk_fast) begin
    if (pulse_out) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_id", int'(pulse_id), e.id);
        chk("pulse_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic nxt();
    @(negedge clk_fast);
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int nb;

    nxt();
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_id", int'(pulse_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovf", int'(ovf), 0);
    nxt();
    rst_n = 1'b1;
    repeat (4) nxt();

    // single request, gap 3
    gap_cfg = 8'd3;
    nxt();
    c0 = cyc;
    q.push_back('{0, c0 + 2});
    req_in = 4'b0001;
    nxt();
    req_in = '0;
    chk("s1_pend_set", int'(pending), 1);
    chk("s1_busy_pre", int'(busy), 0);
    nb = 0;
    repeat (8) begin
      nxt();
      nb += int'(busy);
    end
    chk("s1_busy_cycles", nb, 4);
    chk("s1_pend_end", int'(pending), 0);
    chk("s1_id_hold", int'(pulse_id), 0);

    // all four at once, gap 2
    do_reset();
    gap_cfg = 8'd2;
    nxt();
    c0 = cyc;
    q.push_back('{0, c0 + 2});
    q.push_back('{1, c0 + 6});
    q.push_back('{2, c0 + 10});
    q.push_back('{3, c0 + 14});
    req_in = 4'b1111;
    nxt();
    req_in = '0;
    repeat (16) nxt();
    chk("s2_ovf", int'(ovf), 0);
    chk("s2_pend", int'(pending), 0);
    chk("s2_busy", int'(busy), 0);
    chk("s2_id_hold", int'(pulse_id), 3);

    // overflow on requester 2 during a requester 1 gap
    gap_cfg = 8'd4;
    nxt();
    c0 = cyc;
    q.push_back('{1, c0 + 2});
    q.push_back('{2, c0 + 8});
    req_in = 4'b0010;
    nxt();
    req_in = '0;
    nxt();
    nxt();
    req_in = 4'b0100;
    nxt();
    req_in = '0;
    gap_cfg = 8'd9;
    nxt();
    chk("s3_ovf_none", int'(ovf), 0);
    chk("s3_pend", int'(pending), 4);
    req_in = 4'b0100;
    nxt();
    nxt();
    req_in = '0;
    chk("s3_ovf_set", int'(ovf), 4);
    nxt();
    nxt();
    chk("s3_pend_clr", int'(pending), 0);
    chk("s3_ovf_sticky", int'(ovf), 4);
    clr_ovf = 1'b1;
    nxt();
    clr_ovf = 1'b0;
    chk("s3_ovf_cleared", int'(ovf), 0);
    repeat (7) nxt();
    chk("s3_gap9_busy", int'(busy), 1);
    nxt();
    chk("s3_gap9_done", int'(busy), 0);

    // request on own grant edge
    do_reset();
    gap_cfg = 8'd2;
    nxt();
    c0 = cyc;
    q.push_back('{0, c0 + 2});
    q.push_back('{0, c0 + 6});
    req_in = 4'b0001;
    nxt();
    chk("s4_pend_a", int'(pending), 1);
    nxt();
    req_in = '0;
    chk("s4_pend_kept", int'(pending), 1);
    chk("s4_ovf_none", int'(ovf), 0);
    repeat (6) nxt();
    chk("s4_pend_end", int'(pending), 0);
    chk("s4_ovf_end", int'(ovf), 0);

    // enable gating, gap 0
    enable  = 1'b0;
    gap_cfg = 8'd0;
    nxt();
    req_in = 4'b0110;
    nxt();
    req_in = '0;
    repeat (5) nxt();
    chk("s5_pend_held", int'(pending), 6);
    chk("s5_busy", int'(busy), 0);
    c0 = cyc;
    q.push_back('{1, c0 + 1});
    q.push_back('{2, c0 + 3});
    enable = 1'b1;
    repeat (5) nxt();
    chk("s5_pend_end", int'(pending), 0);

    // reset during gap discards queue
    gap_cfg = 8'd6;
    nxt();
    c0 = cyc;
    q.push_back('{0, c0 + 2});
    req_in = 4'b0001;
    nxt();
    req_in = '0;
    nxt();
    nxt();
    req_in = 4'b1000;
    nxt();
    req_in = '0;
    chk("s6_pend", int'(pending), 8);
    chk("s6_busy_gap", int'(busy), 1);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("s6_rst_pulse", int'(pulse_out), 0);
    chk("s6_rst_busy", int'(busy), 0);
    chk("s6_rst_pend", int'(pending), 0);
    chk("s6_rst_ovf", int'(ovf), 0);
    chk("s6_rst_id", int'(pulse_id), 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    repeat (12) nxt();
    chk("s6_pend_after", int'(pending), 0);
    chk("s6_busy_after", int'(busy), 0);

    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
